autocorr: RTL and testbench

- Computes the autocorrelation lags r[0..ORDER] of one windowed speech frame and writes them into the r memory that the Levinson-Durbin stage reads through r_rsel/r_r.
- Sits directly upstream of the Levinson stage. ready handshakes the frame: the Levinson stage is started when autocorr returns to ready.
- Sample memory is external with two combinational read ports. One multiply-accumulate is done per cycle.

---
 rtl/autocorr.sv | 120 ++++++++++++
 tb/tb_autocorr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/autocorr.sv
// Autocorrelation of one sample frame: r[k] = sat32((sum x[n]*x[n+k]) >>> SHIFT), k = 0..ORDER.
// One multiply-accumulate per cycle; each lag is written once to the r memory as it completes.
module autocorr #(
    parameter int unsigned N     = 1024,
    parameter int unsigned ORDER = 10,
    parameter int unsigned SHIFT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    output logic [9:0]         s_rsel_a,
    input  logic signed [15:0] s_r_a,
    output logic [9:0]         s_rsel_b,
    input  logic signed [15:0] s_r_b,
    output logic [10:0]        r_wsel,
    output logic [31:0]        r_w,
    output logic               r_we
);

    localparam int unsigned AW    = 10;
    localparam int unsigned KW    = 11;
    localparam int unsigned PW    = 32;
    localparam int unsigned ACC_W = 48;

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t                   state, state_d;
    logic [KW-1:0]            k, k_d;
    logic [AW-1:0]            n, n_d;
    logic signed [ACC_W-1:0]  acc, acc_d;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  shifted;
    logic [ACC_W-1:31]        hi_bits;

    // State, counters, accumulator and registered handshake/address outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            n        <= '0;
            acc      <= '0;
            ready    <= 1'b1;
            r_we     <= 1'b0;
            r_wsel   <= '0;
            s_rsel_a <= '0;
            s_rsel_b <= '0;
        end else begin
            state  <= state_d;
            k      <= k_d;
            n      <= n_d;
            acc    <= acc_d;
            ready  <= (state_d == IDLE);
            r_we   <= (state_d == WRITE);
            r_wsel <= k_d;
            // Addresses only move while accumulating and hold otherwise
            if (state_d == MAC) begin
                s_rsel_a <= n_d;
                s_rsel_b <= AW'(KW'(n_d) + k_d);
            end
        end
    end

    assign prod = s_r_a * s_r_b;

    // Next-state and counter/accumulator update
    always_comb begin
        state_d = state;
        k_d     = k;
        n_d     = n;
        acc_d   = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    k_d     = '0;
                    n_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc + ACC_W'(prod);
                if (KW'(n) == KW'(N - 1) - k) begin
                    state_d = WRITE;
                end else begin
                    n_d = n + AW'(1);
                end
            end
            WRITE: begin
                acc_d = '0;
                n_d   = '0;
                if (k == KW'(ORDER)) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k + KW'(1);
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Floor shift, then clamp to the signed 32-bit range
    assign shifted = acc >>> SHIFT;
    assign hi_bits = shifted[ACC_W-1:31];

    always_comb begin
        r_w = '0;
        if (r_we) begin
            if (hi_bits == '0 || hi_bits == '1) begin
                r_w = shifted[31:0];
            end else if (shifted[ACC_W-1]) begin
                r_w = 32'h8000_0000;
            end else begin
                r_w = 32'h7FFF_FFFF;
            end
        end
    end

endmodule

// File: tb/tb_autocorr.sv
// Self-checking bench for autocorr: three configurations share one sample memory,
// writes are checked against a queue of expected {lag, value} pairs.
module tb_autocorr;

    typedef struct {
        int          lag;
        logic [31:0] val;
    } exp_t;

    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    int   sel;

    logic signed [15:0] x [1024];

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   we_cnt = 0;

    // small: N=8 ORDER=2 SHIFT=0; dflt: defaults; o1: N=1024 ORDER=1 SHIFT=0
    logic        start_s, ready_s, r_we_s;
    logic [9:0]  a_s, b_s;
    logic [10:0] wsel_s;
    logic [31:0] w_s;
    logic        start_d, ready_d, r_we_d;
    logic [9:0]  a_d, b_d;
    logic [10:0] wsel_d;
    logic [31:0] w_d;
    logic        start_o, ready_o, r_we_o;
    logic [9:0]  a_o, b_o;
    logic [10:0] wsel_o;
    logic [31:0] w_o;

    assign start_s = start && (sel == 0);
    assign start_d = start && (sel == 1);
    assign start_o = start && (sel == 2);

    autocorr #(.N(8), .ORDER(2), .SHIFT(0)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .ready(ready_s),
        .s_rsel_a(a_s), .s_r_a(x[a_s]), .s_rsel_b(b_s), .s_r_b(x[b_s]),
        .r_wsel(wsel_s), .r_w(w_s), .r_we(r_we_s)
    );

    autocorr u_dflt (
        .clk(clk), .reset(reset), .start(start_d), .ready(ready_d),
        .s_rsel_a(a_d), .s_r_a(x[a_d]), .s_rsel_b(b_d), .s_r_b(x[b_d]),
        .r_wsel(wsel_d), .r_w(w_d), .r_we(r_we_d)
    );

    autocorr #(.N(1024), .ORDER(1), .SHIFT(0)) u_o1 (
        .clk(clk), .reset(reset), .start(start_o), .ready(ready_o),
        .s_rsel_a(a_o), .s_r_a(x[a_o]), .s_rsel_b(b_o), .s_r_b(x[b_o]),
        .r_wsel(wsel_o), .r_w(w_o), .r_we(r_we_o)
    );

    logic        mon_ready, mon_we;
    logic [10:0] mon_wsel;
    logic [31:0] mon_w;

    always_comb begin
        case (sel)
            0:       begin mon_ready = ready_s; mon_we = r_we_s; mon_wsel = wsel_s; mon_w = w_s; end
            2:       begin mon_ready = ready_o; mon_we = r_we_o; mon_wsel = wsel_o; mon_w = w_o; end
            default: begin mon_ready = ready_d; mon_we = r_we_d; mon_wsel = wsel_d; mon_w = w_d; end
        endcase
    end

    // Scoreboard: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mon_we) begin
            exp_t e;
            we_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got lag=%0d data=%h, none expected", mon_wsel, mon_w);
            end else begin
                e = exp_q.pop_front();
                if (mon_wsel !== 11'(e.lag) || mon_w !== e.val) begin
                    bad++;
                    $display("FAIL r_write: got lag=%0d data=%h, expected lag=%0d data=%h",
                             mon_wsel, mon_w, e.lag, e.val);
                end
            end
        end
    end

    // Reference lag value computed directly from the sample array
    function automatic logic [31:0] model(input int nl, input int k, input int sh);
        longint sum;
        sum = 0;
        for (int i = 0; i < nl - k; i++) sum += longint'(x[i]) * longint'(x[i + k]);
        sum = sum >>> sh;
        if (sum > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
        return 32'(sum);
    endfunction

    task automatic fill(input logic signed [15:0] v);
        for (int i = 0; i < 1024; i++) x[i] = v;
    endtask

    // Counts negedges with ready low, returns once ready is high or the bound expires
    task automatic wait_frame(output int cyc);
        cyc = 0;
        while (mon_ready == 1'b0 && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        sel = 1;
        total += 6;
        if (ready_d !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_d); end
        if (r_we_d !== 1'b0) begin bad++; $display("FAIL reset_r_we: got %b want 0", r_we_d); end
        if (w_d !== 32'd0) begin bad++; $display("FAIL reset_r_w: got %h want 0", w_d); end
        if (wsel_d !== 11'd0) begin bad++; $display("FAIL reset_r_wsel: got %0d want 0", wsel_d); end
        if (a_d !== 10'd0) begin bad++; $display("FAIL reset_s_rsel_a: got %0d want 0", a_d); end
        if (b_d !== 10'd0) begin bad++; $display("FAIL reset_s_rsel_b: got %0d want 0", b_d); end
    endtask

    task automatic test_small_frame;
        int cyc;
        sel = 0;
        fill(16'sd0);
        x[0] = 16'sd1; x[1] = 16'sd2; x[2] = 16'sd3; x[3] = 16'sd4;
        exp_q.push_back('{lag: 0, val: 32'd30});
        exp_q.push_back('{lag: 1, val: 32'd20});
        exp_q.push_back('{lag: 2, val: 32'd11});
        we_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_frame(cyc);
        total += 3;
        if (cyc != 24) begin bad++; $display("FAIL small_latency: got %0d want 24", cyc); end
        if (we_cnt != 3) begin bad++; $display("FAIL small_we_count: got %0d want 3", we_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL small_missing: %0d writes outstanding want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_order1(input bit alternate);
        int cyc;
        sel = 2;
        for (int i = 0; i < 1024; i++) x[i] = !alternate ? 16'sd0 : (i % 2 == 0) ? 16'sh7FFF : -16'sh7FFF;
        exp_q.push_back('{lag: 0, val: alternate ? 32'h7FFF_FFFF : 32'h0});
        exp_q.push_back('{lag: 1, val: alternate ? 32'h8000_0000 : 32'h0});
        we_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_frame(cyc);
        total += 3;
        if (cyc != 2049) begin bad++; $display("FAIL order1_latency: got %0d want 2049", cyc); end
        if (we_cnt != 2) begin bad++; $display("FAIL order1_we_count: got %0d want 2", we_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL order1_missing: %0d writes outstanding want 0", exp_q.size()); exp_q.delete(); end
    endtask

    // Start held high: the first frame completes and the next begins on the first ready cycle
    task automatic test_back_to_back;
        int cyc;
        sel = 1;
        fill(16'sh7FFF);
        exp_q.push_back('{lag: 0, val: 32'h00FF_FC00});
        for (int k = 1; k <= 10; k++) exp_q.push_back('{lag: k, val: model(1024, k, 16)});
        we_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_frame(cyc);
        total += 4;
        if (cyc != 11220) begin bad++; $display("FAIL max_latency: got %0d want 11220", cyc); end
        if (we_cnt != 11) begin bad++; $display("FAIL max_we_count: got %0d want 11", we_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL max_missing: %0d writes outstanding want 0", exp_q.size()); exp_q.delete(); end
        @(negedge clk);
        if (mon_ready !== 1'b0) begin bad++; $display("FAIL held_start_restart: ready=%b want 0", mon_ready); end
    endtask

    // Called while the second back-to-back frame is one cycle in
    task automatic test_reset_mid_frame;
        repeat (499) @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        total += 3;
        if (ready_d !== 1'b1) begin bad++; $display("FAIL async_reset_ready: got %b want 1", ready_d); end
        if (r_we_d !== 1'b0) begin bad++; $display("FAIL async_reset_r_we: got %b want 0", r_we_d); end
        if (we_cnt != 11) begin bad++; $display("FAIL aborted_frame_writes: got %0d want 11", we_cnt); end
        @(negedge clk) reset = 1'b0;
    endtask

    // Start pulses while busy must not restart or queue a frame
    task automatic test_start_ignored;
        int cyc;
        sel = 1;
        fill(-16'sh8000);
        exp_q.push_back('{lag: 0, val: 32'h0100_0000});
        for (int k = 1; k <= 10; k++) exp_q.push_back('{lag: k, val: model(1024, k, 16)});
        we_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (mon_ready == 1'b0 && cyc < LIMIT) begin
            cyc++;
            start = (cyc == 100 || cyc == 5000 || cyc == 11000);
            @(negedge clk);
        end
        start = 1'b0;
        total += 3;
        if (cyc != 11220) begin bad++; $display("FAIL ignored_start_latency: got %0d want 11220", cyc); end
        if (we_cnt != 11) begin bad++; $display("FAIL ignored_start_we_count: got %0d want 11", we_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL min_missing: %0d writes outstanding want 0", exp_q.size()); exp_q.delete(); end
        repeat (3) @(negedge clk);
        total++;
        if (mon_ready !== 1'b1) begin bad++; $display("FAIL no_queued_start: ready=%b want 1", mon_ready); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sel   = 1;
        fill(16'sd0);
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_small_frame();
        test_order1(1'b1);
        test_order1(1'b0);
        test_back_to_back();
        test_reset_mid_frame();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
